// File: rtl/pkt_vc_sched_if.sv
// Handshake bundle between the per-VC packetizers, the VC scheduler and the packet processor.
// master drives the request side and out_ready_i; slave is the scheduler.
interface pkt_vc_sched_if #(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned FlitDataWidth = 64,
    parameter int unsigned VcWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic [NumReq-1:0]               req_valid_i;
    logic [NumReq-1:0]               req_new_i;
    logic [NumReq-1:0]               req_last_i;
    logic [NumReq*FlitDataWidth-1:0] req_data_i;
    logic [NumReq-1:0]               req_ready_o;
    logic                            out_valid_o;
    logic                            out_new_o;
    logic                            out_last_o;
    logic [VcWidth-1:0]              out_vc_id_o;
    logic [FlitDataWidth-1:0]        out_data_o;
    logic                            out_ready_i;
    logic                            busy_o;
    logic                            err_o;

    modport master (
        output req_valid_i, req_new_i, req_last_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_new_o, out_last_o, out_vc_id_o, out_data_o,
               busy_o, err_o
    );

    modport slave (
        input  req_valid_i, req_new_i, req_last_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_new_o, out_last_o, out_vc_id_o, out_data_o,
               busy_o, err_o
    );
endinterface

// File: rtl/pkt_vc_sched.sv
// Packet-granular round-robin scheduler sharing the NI-to-router injection path between VCs.
// A winning head locks the path to its VC until that VC's tail flit is accepted.
module pkt_vc_sched #(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned FlitDataWidth = 64,
    parameter int unsigned VcWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input logic           clk_noc,
    input logic           arst_noc,
    pkt_vc_sched_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e             state_q;
    logic [VcWidth-1:0] rr_ptr_q;
    logic [VcWidth-1:0] lock_vc_q;
    logic               head_acc_q;
    logic               err_q;

    logic [NumReq-1:0]        eligible;
    logic                     found;
    logic [VcWidth-1:0]       arb_idx;
    logic [VcWidth-1:0]       gnt_idx;
    logic                     gnt_valid;
    logic                     gnt_new;
    logic                     gnt_last;
    logic [FlitDataWidth-1:0] gnt_data;
    logic                     accept;
    logic [VcWidth-1:0]       rr_next;

    // Round-robin search: first pass from rr_ptr upward, second pass wraps to index 0.
    always_comb begin
        eligible = bus.req_valid_i & bus.req_new_i;
        found    = 1'b0;
        arb_idx  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && eligible[i] && (VcWidth'(i) >= rr_ptr_q)) begin
                found   = 1'b1;
                arb_idx = VcWidth'(i);
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!found && eligible[i]) begin
                found   = 1'b1;
                arb_idx = VcWidth'(i);
            end
        end
    end

    always_comb begin
        gnt_idx   = (state_q == StLocked) ? lock_vc_q : arb_idx;
        gnt_valid = 1'b0;
        gnt_new   = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (VcWidth'(i) == gnt_idx) begin
                gnt_valid = (state_q == StLocked) ? bus.req_valid_i[i] : found;
                gnt_new   = bus.req_new_i[i];
                gnt_last  = bus.req_last_i[i];
                gnt_data  = bus.req_data_i[i*FlitDataWidth +: FlitDataWidth];
            end
        end
        // Outputs are combinational from the inputs, so reset has to mask them explicitly.
        gnt_valid = gnt_valid & ~arst_noc;
        accept    = gnt_valid & bus.out_ready_i;
        rr_next   = (gnt_idx == VcWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        bus.req_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            bus.req_ready_o[i] = accept && (VcWidth'(i) == gnt_idx);
        end
        bus.out_valid_o = gnt_valid;
        bus.out_new_o   = gnt_valid & gnt_new;
        bus.out_last_o  = gnt_valid & gnt_last;
        bus.out_vc_id_o = gnt_valid ? gnt_idx : '0;
        bus.out_data_o  = gnt_valid ? gnt_data : '0;
        bus.busy_o      = (state_q == StLocked);
        bus.err_o       = err_q;
    end

    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_vc_q  <= '0;
            head_acc_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|(bus.req_valid_i & ~bus.req_new_i)) begin
                        err_q <= 1'b1;
                    end
                    if (gnt_valid) begin
                        lock_vc_q  <= gnt_idx;
                        rr_ptr_q   <= rr_next;
                        head_acc_q <= accept;
                        // A presented-but-unaccepted head still claims the path.
                        if (!(accept && gnt_last)) begin
                            state_q <= StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (accept) begin
                        head_acc_q <= 1'b1;
                        if (head_acc_q && gnt_new) begin
                            err_q <= 1'b1;
                        end
                        if (gnt_last) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_vc_sched.sv
// Bench for pkt_vc_sched: directed packet scenarios with literal expectations, then randomized
// per-VC packet sources, all checked every cycle against a behavioural scheduler model.
module tb_pkt_vc_sched;
    localparam int unsigned NumReq        = 3;
    localparam int unsigned FlitDataWidth = 64;
    localparam int unsigned VcWidth       = 2;

    logic clk_noc  = 1'b0;
    logic arst_noc = 1'b1;
    always #5 clk_noc = ~clk_noc;

    pkt_vc_sched_if #(.NumReq(NumReq), .FlitDataWidth(FlitDataWidth), .VcWidth(VcWidth)) bus ();

    pkt_vc_sched #(.NumReq(NumReq), .FlitDataWidth(FlitDataWidth), .VcWidth(VcWidth)) dut (
        .clk_noc (clk_noc),
        .arst_noc(arst_noc),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: packet lock, owner VC, round-robin start, head-seen flag, pending error.
    bit m_locked, m_hacc, m_err;
    int m_lock, m_rr;

    always @(negedge clk_noc) begin : model_cmp
        int g, i;
        bit gv, acc, nw, lst;
        logic [NumReq-1:0] rdy;
        if (arst_noc) begin
            m_locked = 0; m_lock = 0; m_rr = 0; m_hacc = 0; m_err = 0;
        end
        g = 0; gv = 0;
        if (!arst_noc) begin
            if (m_locked) begin
                g  = m_lock;
                gv = bus.req_valid_i[g];
            end else begin
                for (int k = 0; k < NumReq; k++) begin
                    i = (m_rr + k) % NumReq;
                    if (!gv && bus.req_valid_i[i] && bus.req_new_i[i]) begin
                        gv = 1; g = i;
                    end
                end
            end
        end
        acc = gv && bus.out_ready_i;
        nw  = gv && bus.req_new_i[g];
        lst = gv && bus.req_last_i[g];
        rdy = '0;
        if (acc) rdy[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready_o), 64'(rdy));
        check("out_valid", 64'(bus.out_valid_o), 64'(gv));
        check("out_vc_id", 64'(bus.out_vc_id_o), gv ? 64'(g) : 64'd0);
        check("out_new", 64'(bus.out_new_o), 64'(nw));
        check("out_last", 64'(bus.out_last_o), 64'(lst));
        check("out_data", bus.out_data_o, gv ? bus.req_data_i[g*FlitDataWidth +: FlitDataWidth] : 64'd0);
        check("busy", 64'(bus.busy_o), 64'(m_locked));
        check("err", 64'(bus.err_o), 64'(m_err));
        if (!arst_noc) begin
            m_err = 0;
            if (!m_locked) begin
                for (int k = 0; k < NumReq; k++)
                    if (bus.req_valid_i[k] && !bus.req_new_i[k]) m_err = 1;
                if (gv) begin
                    m_lock   = g;
                    m_rr     = (g + 1) % NumReq;
                    m_hacc   = acc;
                    m_locked = !(acc && lst);
                end
            end else if (acc) begin
                if (m_hacc && nw) m_err = 1;
                m_hacc = 1;
                if (lst) m_locked = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic put(input int v, input bit val, input bit nw, input bit lst);
        bus.req_valid_i[v] = val;
        bus.req_new_i[v]   = nw;
        bus.req_last_i[v]  = lst;
        bus.req_data_i[v*FlitDataWidth +: FlitDataWidth] = {$urandom, $urandom};
    endtask

    // Literal expectations sampled on the falling edge of the current cycle.
    task automatic expect_lit(input string tag, input logic [2:0] rdy, input bit ov,
                              input int vc, input bit busy, input bit err);
        @(negedge clk_noc);
        check({tag, ".ready"}, 64'(bus.req_ready_o), 64'(rdy));
        check({tag, ".valid"}, 64'(bus.out_valid_o), 64'(ov));
        if (ov) check({tag, ".vc"}, 64'(bus.out_vc_id_o), 64'(vc));
        check({tag, ".busy"}, 64'(bus.busy_o), 64'(busy));
        check({tag, ".err"}, 64'(bus.err_o), 64'(err));
    endtask

    int len[NumReq];
    int pos[NumReq];
    logic [NumReq-1:0] acc_seen;

    initial begin
        bus.req_valid_i = '0; bus.req_new_i = '0; bus.req_last_i = '0; bus.req_data_i = '0;
        bus.out_ready_i = 1'b1;
        put(0, 1, 1, 0);
        expect_lit("reset_masks", 3'b000, 0, 0, 0, 0);
        cyc();
        put(0, 0, 0, 0);
        arst_noc = 1'b0;
        cyc();

        // VC1 head/body/tail back to back
        put(1, 1, 1, 0); expect_lit("vc1_head", 3'b010, 1, 1, 0, 0); cyc();
        put(1, 1, 0, 0); expect_lit("vc1_body", 3'b010, 1, 1, 1, 0); cyc();
        put(1, 1, 0, 1); expect_lit("vc1_tail", 3'b010, 1, 1, 1, 0);
        check("vc1_tail.last", 64'(bus.out_last_o), 64'd1);
        cyc();
        put(1, 0, 0, 0); expect_lit("vc1_done", 3'b000, 0, 0, 0, 0); cyc();

        // rr_ptr is 2: single-flit VC2 beats a simultaneous VC0 head
        put(2, 1, 1, 1); put(0, 1, 1, 0);
        expect_lit("rr2_single", 3'b100, 1, 2, 0, 0); cyc();
        put(2, 0, 0, 0); expect_lit("vc0_head", 3'b001, 1, 0, 0, 0); cyc();
        put(0, 1, 0, 1); put(1, 1, 1, 0);
        expect_lit("vc0_tail_vc1_blocked", 3'b001, 1, 0, 1, 0); cyc();

        // Backpressure on VC1 head; VC2 head arrives and must wait
        put(0, 0, 0, 0); bus.out_ready_i = 1'b0;
        expect_lit("bp_grant", 3'b000, 1, 1, 0, 0); cyc();
        put(2, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            expect_lit("bp_hold", 3'b000, 1, 1, 1, 0); cyc();
        end
        bus.out_ready_i = 1'b1;
        expect_lit("bp_release", 3'b010, 1, 1, 1, 0); cyc();

        // Bubble on locked VC1 while VC2 head waits
        put(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_lit("bubble", 3'b000, 0, 0, 1, 0); cyc();
        end
        put(1, 1, 0, 1); expect_lit("bubble_tail", 3'b010, 1, 1, 1, 0); cyc();
        put(1, 0, 0, 0); expect_lit("vc2_head", 3'b100, 1, 2, 0, 0); cyc();

        // Second head mid-packet on VC2
        put(2, 1, 1, 0); expect_lit("dup_head", 3'b100, 1, 2, 1, 0);
        check("dup_head.new", 64'(bus.out_new_o), 64'd1);
        cyc();
        put(2, 1, 0, 1); expect_lit("dup_head_err", 3'b100, 1, 2, 1, 1); cyc();

        // Body flit on VC0 in IDLE
        put(2, 0, 0, 0); put(0, 1, 0, 0);
        expect_lit("idle_body", 3'b000, 0, 0, 0, 0); cyc();
        put(0, 0, 0, 0); expect_lit("idle_body_err", 3'b000, 0, 0, 0, 1); cyc();
        expect_lit("err_cleared", 3'b000, 0, 0, 0, 0); cyc();

        // Randomized packet sources with a mid-run reset
        for (int i = 0; i < NumReq; i++) begin
            pos[i] = 0;
            len[i] = $urandom_range(1, 4);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_noc);
            acc_seen = bus.req_valid_i & bus.req_ready_o;
            cyc();
            arst_noc = (c == 1500 || c == 1501);
            for (int i = 0; i < NumReq; i++) begin
                if (c == 1500) begin
                    pos[i] = 0;
                    len[i] = $urandom_range(1, 4);
                    bus.req_valid_i[i] = 1'b0;
                end else if (acc_seen[i]) begin
                    bus.req_valid_i[i] = 1'b0;
                    pos[i]++;
                    if (pos[i] == len[i]) begin
                        pos[i] = 0;
                        len[i] = $urandom_range(1, 4);
                    end
                end
                if (!bus.req_valid_i[i] && $urandom_range(0, 3) != 0) begin
                    put(i, 1, (pos[i] == 0) || ($urandom_range(0, 15) == 0), pos[i] == len[i] - 1);
                end
            end
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk_noc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
